// File: rtl/ppu_pkg.sv
// ppu_pkg: shared FSM state type and PPU latency constants for the PPU sequencer
package ppu_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    localparam int PPU_LAT_BYPASS = 1;
    localparam int PPU_LAT_POOL = 2;
endpackage

// File: rtl/ppu_seq_ctrl_if.sv
// ppu_seq_ctrl_if: psum input stream and result output stream of the PPU sequencer
interface ppu_seq_ctrl_if #(parameter int DATA_BITS = 32, parameter int ADDR_W = 16);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_BITS-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic [ADDR_W-1:0]    out_addr;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_addr);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_addr);
endinterface

// File: rtl/ppu_out_fifo.sv
// ppu_out_fifo: synchronous FIFO with occupancy count; push and pop may coincide even when full
module ppu_out_fifo #(parameter int WIDTH = 8, parameter int DEPTH = 4) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
    assign dout = mem_q[rd_q];
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d = wr_q + AW'(push);
        rd_d = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // Credit gating upstream guarantees a free slot for every push
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/ppu_seq_ctrl.sv
// ppu_seq_ctrl: feeds one PPU from the psum stream, tracks its latency and buffers
// results with their output-buffer addresses; input is credit-gated on FIFO space.
module ppu_seq_ctrl import ppu_pkg::*; #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_W = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_relu_en,
    input  logic [5:0]           cfg_scaling,
    input  logic                 cfg_pool_en,
    input  logic [3:0]           cfg_pool_len,
    input  logic [ADDR_W-1:0]    cfg_out_cnt,
    input  logic [ADDR_W-1:0]    cfg_base_addr,
    output logic                 busy,
    output logic                 done,
    ppu_seq_ctrl_if.slave        s,
    output logic [DATA_BITS-1:0] ppu_data_in,
    output logic [5:0]           ppu_scaling_factor,
    output logic                 ppu_relu_en,
    output logic                 ppu_relu_sel,
    output logic                 ppu_maxpool_en,
    output logic                 ppu_maxpool_init,
    input  logic [7:0]           ppu_data_out
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    state_e state_q, state_d;
    logic relu_q, relu_d, pool_q, pool_d, tag1_q, tag1_d, tag2_q, tag2_d;
    logic [5:0] scale_q, scale_d;
    logic [3:0] len_q, len_d, elem_q, elem_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, base_q, base_d, win_q, win_d, idx_q, idx_d;
    logic [CW-1:0] fly_q, fly_d, fifo_cnt;
    logic [CW:0] used;
    logic fire, win_end, fifo_empty, pop;
    assign used = {1'b0, fifo_cnt} + {1'b0, fly_q};
    // The first element of a window needs a free credit; later ones already hold it
    assign s.in_ready = state_q == RUN && (elem_q != '0 || used < (CW+1)'(OUT_DEPTH));
    assign fire = s.in_valid && s.in_ready;
    assign win_end = fire && elem_q == len_q - 4'd1;
    assign ppu_maxpool_en = fire && pool_q;
    assign ppu_maxpool_init = ppu_maxpool_en && elem_q == '0;
    assign ppu_data_in = s.in_data;
    assign ppu_scaling_factor = scale_q;
    assign ppu_relu_en = relu_q;
    assign ppu_relu_sel = pool_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign s.out_valid = !fifo_empty;
    assign pop = s.out_valid && s.out_ready;
    always_comb begin
        state_d = state_q;
        relu_d = relu_q;
        pool_d = pool_q;
        scale_d = scale_q;
        len_d = len_q;
        cnt_d = cnt_q;
        base_d = base_q;
        elem_d = fire ? (win_end ? 4'd0 : elem_q + 4'd1) : elem_q;
        win_d = win_q + ADDR_W'(win_end);
        idx_d = idx_q + ADDR_W'(tag2_q);
        fly_d = fly_q + CW'(fire && elem_q == '0) - CW'(tag2_q);
        tag1_d = win_end && pool_q;
        tag2_d = tag1_q || (win_end && !pool_q);
        case (state_q)
            IDLE: if (cfg_start) begin
                relu_d = cfg_relu_en;
                pool_d = cfg_pool_en;
                scale_d = cfg_scaling;
                len_d = cfg_pool_en && cfg_pool_len != '0 ? cfg_pool_len : 4'd1;
                cnt_d = cfg_out_cnt;
                base_d = cfg_base_addr;
                elem_d = '0;
                win_d = '0;
                idx_d = '0;
                fly_d = '0;
                state_d = cfg_out_cnt == '0 ? DONE : RUN;
            end
            RUN: state_d = win_end && win_q == cnt_q - ADDR_W'(1) ? DRAIN : RUN;
            DRAIN: state_d = !tag1_q && !tag2_q && fifo_empty ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            relu_q <= 1'b0;
            pool_q <= 1'b0;
            scale_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            base_q <= '0;
            elem_q <= '0;
            win_q <= '0;
            idx_q <= '0;
            fly_q <= '0;
            tag1_q <= 1'b0;
            tag2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            relu_q <= relu_d;
            pool_q <= pool_d;
            scale_q <= scale_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            base_q <= base_d;
            elem_q <= elem_d;
            win_q <= win_d;
            idx_q <= idx_d;
            fly_q <= fly_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
        end
    end
    ppu_out_fifo #(.WIDTH(8 + ADDR_W), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(tag2_q),
        .pop(pop),
        .din({ppu_data_out, base_q + idx_q}),
        .dout({s.out_data, s.out_addr}),
        .empty(fifo_empty),
        .count(fifo_cnt)
    );
endmodule

// File: tb/tb_ppu_seq_ctrl.sv
// tb_ppu_seq_ctrl: directed tests of ppu_seq_ctrl against a cycle-accurate PPU stub
module tb_ppu_seq_ctrl;
    import ppu_pkg::*;
    logic clk = 0, rst = 1;
    logic cfg_start = 0, cfg_relu_en = 0, cfg_pool_en = 0;
    logic [5:0] cfg_scaling = 0;
    logic [3:0] cfg_pool_len = 0;
    logic [15:0] cfg_out_cnt = 0, cfg_base_addr = 0;
    logic busy, done;
    logic [31:0] ppu_data_in;
    logic [5:0] ppu_scaling_factor;
    logic ppu_relu_en, ppu_relu_sel, ppu_maxpool_en, ppu_maxpool_init;
    logic [7:0] ppu_data_out;
    logic [31:0] cmp;
    int total = 0, bad = 0, cyc = 0;
    int fire_cyc[$], init_idx[$], pc[$];
    logic [7:0] pd[$];
    logic [15:0] pa[$];
    int en_n = 0, rdy_n = 0, done_n = 0;

    ppu_seq_ctrl_if #(.DATA_BITS(32), .ADDR_W(16)) bus();

    ppu_seq_ctrl #(.DATA_BITS(32), .ADDR_W(16), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_relu_en(cfg_relu_en),
        .cfg_scaling(cfg_scaling), .cfg_pool_en(cfg_pool_en), .cfg_pool_len(cfg_pool_len),
        .cfg_out_cnt(cfg_out_cnt), .cfg_base_addr(cfg_base_addr), .busy(busy), .done(done),
        .s(bus.slave), .ppu_data_in(ppu_data_in), .ppu_scaling_factor(ppu_scaling_factor),
        .ppu_relu_en(ppu_relu_en), .ppu_relu_sel(ppu_relu_sel), .ppu_maxpool_en(ppu_maxpool_en),
        .ppu_maxpool_init(ppu_maxpool_init), .ppu_data_out(ppu_data_out)
    );

    // PPU stub: identity quant, comparator then output register
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp <= 0;
            ppu_data_out <= 0;
        end else begin
            if (ppu_maxpool_en)
                cmp <= (ppu_maxpool_init || $signed(ppu_data_in) > $signed(cmp)) ? ppu_data_in : cmp;
            ppu_data_out <= ppu_relu_sel ? cmp[7:0] : ppu_data_in[7:0];
        end
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                if (ppu_maxpool_init) init_idx.push_back(fire_cyc.size());
                if (ppu_maxpool_en) en_n++;
                fire_cyc.push_back(cyc);
            end
            if (bus.in_ready) rdy_n++;
            if (bus.out_valid && bus.out_ready) begin
                pd.push_back(bus.out_data);
                pa.push_back(bus.out_addr);
                pc.push_back(cyc);
            end
            if (done) done_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task clear_log;
        fire_cyc.delete(); init_idx.delete(); pc.delete(); pd.delete(); pa.delete();
        en_n = 0; rdy_n = 0; done_n = 0;
    endtask

    task start_layer(input logic relu, input logic [5:0] sc, input logic pe, input logic [3:0] pl,
                     input logic [15:0] oc, input logic [15:0] base);
        @(negedge clk);
        cfg_relu_en = relu; cfg_scaling = sc; cfg_pool_en = pe; cfg_pool_len = pl;
        cfg_out_cnt = oc; cfg_base_addr = base; cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
    endtask

    task send(input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1; bus.in_data = v;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (n >= 200) begin bad++; $display("FAIL send_timeout data=%0d in_ready=%b required=1", v, bus.in_ready); end
    endtask

    task wait_done(input int lim);
        int n;
        n = 0;
        while (done_n == 0 && n < lim) begin @(negedge clk); #3; n++; end
        total++;
        if (done_n !== 1) begin bad++; $display("FAIL done_count got=%0d required=1", done_n); end
        @(negedge clk); #1;
        total++;
        if (busy !== 0) begin bad++; $display("FAIL busy_after_done got=%b required=0", busy); end
    endtask

    task test_reset;
        bus.in_valid = 1; bus.in_data = 0; bus.out_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({busy, done, bus.in_ready, bus.out_valid, ppu_maxpool_en, ppu_maxpool_init, ppu_relu_en, ppu_relu_sel} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b required=00000000",
                {busy, done, bus.in_ready, bus.out_valid, ppu_maxpool_en, ppu_maxpool_init, ppu_relu_en, ppu_relu_sel});
        end
        total++;
        if ({bus.out_data, bus.out_addr, ppu_scaling_factor} !== 30'h0) begin
            bad++; $display("FAIL reset_data data=%h addr=%h scale=%h required=0", bus.out_data, bus.out_addr, ppu_scaling_factor);
        end
        bus.in_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task test_bypass;
        logic [7:0] ed [3];
        ed = '{8'd5, 8'd9, 8'd3};
        clear_log();
        bus.out_ready = 1;
        start_layer(0, 0, 0, 0, 3, 16'h10);
        send(5); send(9); send(3);
        @(negedge clk); bus.in_valid = 0;
        wait_done(100);
        total++;
        if (pd.size() != 3 || fire_cyc.size() != 3) begin
            bad++; $display("FAIL bypass_count pops=%0d fires=%0d required=3", pd.size(), fire_cyc.size());
        end else for (int i = 0; i < 3; i++) begin
            total++;
            if (pd[i] !== ed[i] || pa[i] !== 16'h10 + 16'(i) || pc[i] != fire_cyc[i] + PPU_LAT_BYPASS + 1) begin
                bad++; $display("FAIL bypass_out%0d data=%0d addr=%h cyc=%0d required data=%0d addr=%h cyc=%0d",
                    i, pd[i], pa[i], pc[i], ed[i], 16'h10 + 16'(i), fire_cyc[i] + PPU_LAT_BYPASS + 1);
            end
        end
        total++;
        if (en_n != 0 || init_idx.size() != 0) begin
            bad++; $display("FAIL bypass_strobes en=%0d init=%0d required=0", en_n, init_idx.size());
        end
    endtask

    task test_pool;
        int v [8];
        v = '{5, 9, 3, 7, 1, 2, 8, 4};
        clear_log();
        bus.out_ready = 1;
        start_layer(0, 0, 1, 4, 2, 16'h20);
        for (int i = 0; i < 8; i++) send(v[i]);
        @(negedge clk); bus.in_valid = 0;
        wait_done(100);
        total++;
        if (init_idx.size() != 2 || init_idx[0] != 0 || init_idx[1] != 4) begin
            bad++; $display("FAIL pool_init count=%0d required elements 0 and 4", init_idx.size());
        end
        total++;
        if (en_n != 8) begin bad++; $display("FAIL pool_en got=%0d required=8", en_n); end
        total++;
        if (pd.size() != 2 || fire_cyc.size() != 8) begin
            bad++; $display("FAIL pool_count pops=%0d fires=%0d required 2/8", pd.size(), fire_cyc.size());
        end else begin
            total++;
            if (pd[0] !== 8'd9 || pa[0] !== 16'h20 || pc[0] != fire_cyc[3] + PPU_LAT_POOL + 1) begin
                bad++; $display("FAIL pool_out0 data=%0d addr=%h cyc=%0d required 9/20/%0d", pd[0], pa[0], pc[0], fire_cyc[3] + PPU_LAT_POOL + 1);
            end
            total++;
            if (pd[1] !== 8'd8 || pa[1] !== 16'h21 || pc[1] != fire_cyc[7] + PPU_LAT_POOL + 1) begin
                bad++; $display("FAIL pool_out1 data=%0d addr=%h cyc=%0d required 8/21/%0d", pd[1], pa[1], pc[1], fire_cyc[7] + PPU_LAT_POOL + 1);
            end
        end
    endtask

    task test_credit;
        int v [5];
        int k;
        v = '{11, 22, 33, 44, 55};
        k = 0;
        clear_log();
        bus.out_ready = 0;
        start_layer(0, 0, 1, 1, 4, 16'h30);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.in_valid = 1; bus.in_data = v[k];
            #1;
            if (bus.in_ready) k++;
        end
        #2;
        total++;
        if (fire_cyc.size() != 4) begin bad++; $display("FAIL credit_fires got=%0d required=4", fire_cyc.size()); end
        total++;
        if (bus.in_ready !== 0 || bus.out_valid !== 1) begin
            bad++; $display("FAIL credit_stall in_ready=%b out_valid=%b required 0/1", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        bus.out_ready = 1;
        wait_done(100);
        bus.in_valid = 0;
        total++;
        if (pd.size() != 4 || fire_cyc.size() != 4) begin
            bad++; $display("FAIL credit_count pops=%0d fires=%0d required=4", pd.size(), fire_cyc.size());
        end else for (int i = 0; i < 4; i++) begin
            total++;
            if (pd[i] !== 8'(v[i]) || pa[i] !== 16'h30 + 16'(i)) begin
                bad++; $display("FAIL credit_out%0d data=%0d addr=%h required %0d/%h", i, pd[i], pa[i], v[i], 16'h30 + 16'(i));
            end
        end
    endtask

    task test_random;
        int v [144];
        int k, n;
        logic [7:0] m;
        for (int i = 0; i < 144; i++) v[i] = $urandom_range(0, 255);
        k = 0; n = 0;
        clear_log();
        start_layer(0, 0, 1, 9, 16, 16'h100);
        while (k < 144 && n < 4000) begin
            @(negedge clk);
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 2) != 0;
            bus.in_data = v[k];
            #1;
            if (bus.in_valid && bus.in_ready) k++;
            n++;
        end
        @(negedge clk);
        bus.in_valid = 0; bus.out_ready = 1;
        wait_done(200);
        total++;
        if (pd.size() != 16 || fire_cyc.size() != 144) begin
            bad++; $display("FAIL random_count pops=%0d fires=%0d required 16/144", pd.size(), fire_cyc.size());
        end else for (int w = 0; w < 16; w++) begin
            m = 0;
            for (int j = 0; j < 9; j++) if (8'(v[w*9+j]) > m) m = 8'(v[w*9+j]);
            total++;
            if (pd[w] !== m || pa[w] !== 16'h100 + 16'(w)) begin
                bad++; $display("FAIL random_out%0d data=%0d addr=%h required %0d/%h", w, pd[w], pa[w], m, 16'h100 + 16'(w));
            end
        end
    endtask

    task test_zero_and_busy_start;
        clear_log();
        bus.out_ready = 1;
        @(negedge clk);
        bus.in_valid = 1; cfg_out_cnt = 0; cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
        #1;
        total++;
        if (done !== 1 || busy !== 1) begin bad++; $display("FAIL zero_done done=%b busy=%b required 1/1", done, busy); end
        @(negedge clk); #1;
        total++;
        if (done !== 0 || busy !== 0 || rdy_n != 0) begin
            bad++; $display("FAIL zero_end done=%b busy=%b ready_cycles=%0d required 0/0/0", done, busy, rdy_n);
        end
        bus.in_valid = 0;
        clear_log();
        start_layer(1, 3, 0, 0, 2, 16'h40);
        @(negedge clk);
        cfg_relu_en = 0; cfg_scaling = 7; cfg_pool_en = 1; cfg_out_cnt = 5; cfg_base_addr = 16'h99; cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
        #1;
        total++;
        if (ppu_scaling_factor !== 6'd3 || ppu_relu_en !== 1 || ppu_relu_sel !== 0) begin
            bad++; $display("FAIL busy_cfg scale=%0d relu=%b sel=%b required 3/1/0", ppu_scaling_factor, ppu_relu_en, ppu_relu_sel);
        end
        send(12); send(34);
        @(negedge clk); bus.in_valid = 0;
        wait_done(100);
        total++;
        if (pd.size() != 2 || pd[0] !== 8'd12 || pd[1] !== 8'd34 || pa[0] !== 16'h40 || pa[1] !== 16'h41) begin
            bad++; $display("FAIL busy_out pops=%0d required 2 results 12@40 34@41", pd.size());
        end
    endtask

    task test_reset_mid;
        clear_log();
        bus.out_ready = 0;
        start_layer(1, 5, 1, 2, 3, 16'h50);
        send(7); send(3);
        @(negedge clk); bus.in_valid = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1) begin bad++; $display("FAIL mid_prefill out_valid=%b required=1", bus.out_valid); end
        send(6);
        @(negedge clk);
        rst = 1;
        #1;
        total++;
        if ({busy, done, bus.in_ready, bus.out_valid, ppu_maxpool_en, ppu_maxpool_init, ppu_relu_en, ppu_relu_sel} !== 8'h00
            || {bus.out_data, bus.out_addr, ppu_scaling_factor} !== 30'h0) begin
            bad++; $display("FAIL mid_reset ctrl=%b data=%h addr=%h scale=%h required all 0",
                {busy, done, bus.in_ready, bus.out_valid, ppu_maxpool_en, ppu_maxpool_init, ppu_relu_en, ppu_relu_sel},
                bus.out_data, bus.out_addr, ppu_scaling_factor);
        end
        bus.in_valid = 0;
        @(negedge clk);
        rst = 0;
        test_bypass();
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
        test_reset();
        test_bypass();
        test_pool();
        test_credit();
        test_random();
        test_zero_and_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
